hilo_muldiv_unit: RTL

- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath.
- Consumes the two register-file read ports from decode, alongside the ALU.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO to the write-back mux for MFHI/MFLO. Control stalls the PC while Busy is high.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/hilo_muldiv_unit_if.sv | 17 +
 rtl/muldiv_datapath.sv | 66 ++++++
 rtl/hilo_muldiv_unit.sv | 123 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and default widths.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between decode/control and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(parameter int WIDTH = muldiv_pkg::WIDTH_DEF);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] RsData;
  logic [WIDTH-1:0] RtData;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (output Start, Op, RsData, RtData, Flush,
                  input  Busy, Done, Hi, Lo);
  modport slave  (input  Start, Op, RsData, RtData, Flush,
                  output Busy, Done, Hi, Lo);
endinterface

// File: rtl/muldiv_datapath.sv
// Unsigned magnitude engine: radix-2 shift-add multiply and restoring divide,
// one bit per step, with the iteration counter.
module muldiv_datapath #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi_mag,
  output logic [WIDTH-1:0] quo,
  output logic             last
);

  // acc is one bit wider than the operands so partial sums/remainders never wrap.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_diff;
  logic             sub_ok;

  always_comb begin
    add_sum  = acc + {1'b0, b_reg};
    shifted  = {acc[WIDTH-1:0], quo[WIDTH-1]};
    sub_diff = shifted - {1'b0, b_reg};
    sub_ok   = (shifted >= {1'b0, b_reg});
  end

  assign hi_mag = acc[WIDTH-1:0];
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      quo   <= '0;
      b_reg <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      quo   <= a_mag;
      b_reg <= b_mag;
      cnt   <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        acc <= sub_ok ? sub_diff : shifted;
        quo <= {quo[WIDTH-2:0], sub_ok};
      end else if (quo[0]) begin
        acc <= {1'b0, add_sum[WIDTH:1]};
        quo <= {add_sum[0], quo[WIDTH-1:1]};
      end else begin
        acc <= {1'b0, acc[WIDTH:1]};
        quo <= {acc[0], quo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: control FSM, sign handling and the architectural
// HI/LO registers around the iterative magnitude datapath.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  hilo_muldiv_unit_if.slave  bus
);

  logic [1:0]         state;
  op_e                op_req;
  logic               signed_op;
  logic               load;
  logic               step;
  logic               last;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   hi_mag;
  logic [WIDTH-1:0]   quo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               is_div_r;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   rs_raw;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;

  assign op_req = op_e'(bus.Op);

  always_comb begin
    signed_op = (op_req == OP_MULT) || (op_req == OP_DIV);
    a_mag     = (signed_op && bus.RsData[WIDTH-1]) ? -bus.RsData : bus.RsData;
    b_mag     = (signed_op && bus.RtData[WIDTH-1]) ? -bus.RtData : bus.RtData;
    load      = (state == S_IDLE) && bus.Start && !bus.Op[2];
    step      = (state == S_RUN) && !bus.Flush;
    prod      = neg_res ? -{hi_mag, quo} : {hi_mag, quo};
    quot_fix  = neg_res ? -quo : quo;
    rem_fix   = neg_rem ? -hi_mag : hi_mag;
  end

  muldiv_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_datapath (
    .clk    (Clk),
    .rst_n  (Reset),
    .load   (load),
    .step   (step),
    .is_div (is_div_r),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi_mag (hi_mag),
    .quo    (quo),
    .last   (last)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= S_IDLE;
      done_r   <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      is_div_r <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      rs_raw   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            case (op_req)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state    <= S_RUN;
                is_div_r <= bus.Op[1];
                neg_res  <= signed_op && (bus.RsData[WIDTH-1] ^ bus.RtData[WIDTH-1]);
                neg_rem  <= signed_op && bus.RsData[WIDTH-1];
                div_zero <= (bus.RtData == '0);
                rs_raw   <= bus.RsData;
              end
              OP_MTHI: hi_r <= bus.RsData;
              OP_MTLO: lo_r <= bus.RsData;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (bus.Flush)  state <= S_IDLE;
          else if (last)  state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!bus.Flush) begin
            done_r <= 1'b1;
            if (!is_div_r) begin
              {hi_r, lo_r} <= prod;
            end else if (div_zero) begin
              // Divide by zero reports the raw dividend and an all-ones quotient.
              hi_r <= rs_raw;
              lo_r <= '1;
            end else begin
              hi_r <= rem_fix;
              lo_r <= quot_fix;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy = (state != S_IDLE);
  assign bus.Done = done_r;
  assign bus.Hi   = hi_r;
  assign bus.Lo   = lo_r;

endmodule
